alu_serial_cmp: RTL and testbench

//  Sequential, bit-serial two's-complement comparator for the 6-bit ALU datapath.

---
 rtl/alu_pkg.sv | 18 +
 rtl/cmp_bit_decide.sv | 16 +
 rtl/alu_serial_cmp.sv | 97 +++++++++
 tb/tb_alu_serial_cmp.sv | 137 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU datapath.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 6;

  typedef enum logic [1:0] {
    CMP_IDLE,
    CMP_SCAN,
    CMP_DONE
  } cmp_state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_flags_t;

endpackage

// File: rtl/cmp_bit_decide.sv
// Single-bit decision step of the MSB-first signed compare.
module cmp_bit_decide (
  input  logic a_bit,
  input  logic b_bit,
  input  logic is_sign,
  output logic decided,
  output logic lt,
  output logic gt
);

  assign decided = a_bit ^ b_bit;
  // At the sign bit a set bit means negative, so the ordering is inverted.
  assign lt = is_sign ? a_bit : b_bit;
  assign gt = is_sign ? b_bit : a_bit;

endmodule

// File: rtl/alu_serial_cmp.sv
// Bit-serial two's-complement comparator: scans MSB-first, stops at the first differing bit.
module alu_serial_cmp
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [WIDTH-1:0] C
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] IdxMsb = IdxW'(WIDTH - 1);

  cmp_state_t      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  cmp_flags_t      flags_q, flags_d;

  logic bit_decided, bit_lt, bit_gt;

  cmp_bit_decide u_bit_decide (
    .a_bit   (a_q[idx_q]),
    .b_bit   (b_q[idx_q]),
    .is_sign (idx_q == IdxMsb),
    .decided (bit_decided),
    .lt      (bit_lt),
    .gt      (bit_gt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    flags_d = flags_q;
    unique case (state_q)
      CMP_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          idx_d   = IdxMsb;
          state_d = CMP_SCAN;
        end
      end
      CMP_SCAN: begin
        if (bit_decided) begin
          flags_d.lt = bit_lt;
          flags_d.eq = 1'b0;
          flags_d.gt = bit_gt;
          state_d    = CMP_DONE;
        end else if (idx_q == '0) begin
          flags_d.lt = 1'b0;
          flags_d.eq = 1'b1;
          flags_d.gt = 1'b0;
          state_d    = CMP_DONE;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      CMP_DONE: state_d = CMP_IDLE;
      default:  state_d = CMP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CMP_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      flags_q <= flags_d;
    end
  end

  assign busy = (state_q != CMP_IDLE);
  assign done = (state_q == CMP_DONE);
  assign lt   = flags_q.lt;
  assign eq   = flags_q.eq;
  assign gt   = flags_q.gt;
  assign C    = {{(WIDTH - 1){1'b0}}, flags_q.lt};

endmodule

// File: tb/tb_alu_serial_cmp.sv
// Directed self-checking bench for alu_serial_cmp.
module tb_alu_serial_cmp;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] A, B;
  logic       busy, done, lt, eq, gt;
  logic [5:0] C;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  alu_serial_cmp #(.WIDTH(6)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .lt    (lt),
    .eq    (eq),
    .gt    (gt),
    .C     (C)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run one compare; operands are scrambled right after acceptance.
  task automatic run_cmp(input string tag, input logic [5:0] a, input logic [5:0] b,
                         input logic [2:0] exp_flags, input int exp_edges);
    int edges;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = 6'h2a; B = 6'h15;
    edges = 1;
    check({tag, " busy"}, busy, 1'b1);
    while (done !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " edges"}, edges, exp_edges);
    check({tag, " flags"}, {lt, eq, gt}, exp_flags);
    check({tag, " C"}, C, {5'b0, exp_flags[2]});
    @(posedge clk); #1;
    check({tag, " done drop"}, {busy, done}, 2'b00);
    check({tag, " hold"}, {lt, eq, gt}, exp_flags);
  endtask

  logic [5:0] pa[9];
  logic [5:0] pb[9];

  initial begin
    int cnt0;
    reset = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {busy, done, lt, eq, gt, C}, '0);
    @(negedge clk); reset = 1'b0;

    // Set non-zero flags so the mid-scan reset has something to clear.
    run_cmp("T5 7>6", 6'd7, 6'd6, 3'b001, 7);

    // T1: reset in mid-scan of 5 vs 9.
    cnt0 = done_cnt;
    @(negedge clk);
    A = 6'd5; B = 6'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("T1 after reset", {busy, done, lt, eq, gt, C}, '0);
    @(negedge clk); reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("T1 no done", done_cnt, cnt0);
    check("T1 idle", {busy, lt, eq, gt, C}, '0);

    run_cmp("T2 -32<31", 6'b100000, 6'b011111, 3'b100, 2);
    run_cmp("T2 31>-32", 6'b011111, 6'b100000, 3'b001, 2);
    run_cmp("T3 -3<-2", 6'b111101, 6'b111110, 3'b100, 6);
    run_cmp("T4 -1==-1", 6'b111111, 6'b111111, 3'b010, 7);
    run_cmp("T4 0==0", 6'b000000, 6'b000000, 3'b010, 7);
    run_cmp("T5 0<1", 6'd0, 6'd1, 3'b100, 7);

    // T6: start held high; only pairs 0, 3 and 6 are sampled in IDLE.
    pa[0] = 6'b100000; pb[0] = 6'b011111;
    pa[1] = 6'b011111; pb[1] = 6'b100000;
    pa[2] = 6'b011111; pb[2] = 6'b100000;
    pa[3] = 6'b000101; pb[3] = 6'b111011;
    pa[4] = 6'b111111; pb[4] = 6'b000001;
    pa[5] = 6'b111111; pb[5] = 6'b000001;
    pa[6] = 6'b111110; pb[6] = 6'b000011;
    pa[7] = 6'b000001; pb[7] = 6'b111111;
    pa[8] = 6'b000001; pb[8] = 6'b111111;
    cnt0 = done_cnt;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      A = pa[j]; B = pb[j]; start = (j <= 6);
      @(posedge clk); #1;
      check($sformatf("T6 done@%0d", j), done, (j == 1 || j == 4 || j == 7));
      if (j == 1) check("T6 res0", {lt, eq, gt}, 3'b100);
      if (j == 4) check("T6 res3", {lt, eq, gt}, 3'b001);
      if (j == 7) check("T6 res6", {lt, eq, gt}, 3'b100);
    end
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("T6 done count", done_cnt - cnt0, 3);
    check("T6 idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
